// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, 2-bit saturating branch-counter table
// and the IF/ID pipeline register, with static beq/bne target prediction.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        ICacheStall,
  output logic        IcacheRead,
  output logic [31:0] IcacheAddr,
  input  logic [31:0] IcacheRdata,
  input  logic        IdRedirect,
  input  logic [31:0] IdRedirectPC,
  input  logic        IdBranchValid,
  input  logic [31:0] IdBranchPC,
  input  logic        IdBranchTaken,
  output logic        IfIdValid,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPC,
  output logic [31:0] IfIdPCPlus4,
  output logic        IfIdPredTaken
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [31:0]          pc_q, pc_d;
  logic [1:0]           bht_q [BHT_N];
  logic                 ifid_valid_q, ifid_valid_d;
  logic [31:0]          ifid_instr_q, ifid_instr_d;
  logic [31:0]          ifid_pc_q, ifid_pc_d;
  logic [31:0]          ifid_pc4_q, ifid_pc4_d;
  logic                 ifid_pred_q, ifid_pred_d;

  logic                 hold;
  logic                 is_branch;
  logic                 pred_taken;
  logic [31:0]          pc_plus4;
  logic [31:0]          br_target;
  logic [BHT_IDX_W-1:0] rd_idx;
  logic [BHT_IDX_W-1:0] wr_idx;
  logic [1:0]           ctr_rd;
  logic [1:0]           ctr_upd;
  logic                 unused_pc_bits;

  assign hold       = Stall | ICacheStall;
  assign rd_idx     = pc_q[BHT_IDX_W+1:2];
  assign wr_idx     = IdBranchPC[BHT_IDX_W+1:2];
  assign ctr_rd     = bht_q[rd_idx];
  assign is_branch  = (IcacheRdata[31:26] == 6'h04) || (IcacheRdata[31:26] == 6'h05);
  assign pred_taken = is_branch & ctr_rd[1];
  assign pc_plus4   = pc_q + 32'd4;
  assign br_target  = pc_plus4 + {{14{IcacheRdata[15]}}, IcacheRdata[15:0], 2'b00};
  assign ctr_upd    = IdBranchTaken ? sat_inc(bht_q[wr_idx]) : sat_dec(bht_q[wr_idx]);

  assign unused_pc_bits = ^{IdBranchPC[31:BHT_IDX_W+2], IdBranchPC[1:0]};

  always_comb begin
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_pred_d  = ifid_pred_q;
    if (!hold) begin
      ifid_pc_d  = pc_q;
      ifid_pc4_d = pc_plus4;
      if (IdRedirect) begin
        // Flush: the instruction fetched this cycle is on the wrong path.
        pc_d         = IdRedirectPC;
        ifid_valid_d = 1'b0;
        ifid_instr_d = 32'h0;
        ifid_pred_d  = 1'b0;
      end else begin
        pc_d         = pred_taken ? br_target : pc_plus4;
        ifid_valid_d = 1'b1;
        ifid_instr_d = IcacheRdata;
        ifid_pred_d  = pred_taken;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_pc4_q   <= 32'h0;
      ifid_pred_q  <= 1'b0;
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else begin
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_pred_q  <= ifid_pred_d;
      // Prediction above already used the old counter value (read-before-write).
      if (!hold && IdBranchValid) bht_q[wr_idx] <= ctr_upd;
    end
  end

  assign IcacheRead    = ~rst;
  assign IcacheAddr    = pc_q;
  assign IfIdValid     = ifid_valid_q;
  assign IfIdInstr     = ifid_instr_q;
  assign IfIdPC        = ifid_pc_q;
  assign IfIdPCPlus4   = ifid_pc4_q;
  assign IfIdPredTaken = ifid_pred_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic, all checked
// against a behavioural fetch model kept here.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall = 1'b0;
  logic        ICacheStall = 1'b0;
  logic        IcacheRead;
  logic [31:0] IcacheAddr;
  logic [31:0] IcacheRdata = 32'h0;
  logic        IdRedirect = 1'b0;
  logic [31:0] IdRedirectPC = 32'h0;
  logic        IdBranchValid = 1'b0;
  logic [31:0] IdBranchPC = 32'h0;
  logic        IdBranchTaken = 1'b0;
  logic        IfIdValid;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPC;
  logic [31:0] IfIdPCPlus4;
  logic        IfIdPredTaken;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .BHT_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .ICacheStall(ICacheStall),
    .IcacheRead(IcacheRead), .IcacheAddr(IcacheAddr), .IcacheRdata(IcacheRdata),
    .IdRedirect(IdRedirect), .IdRedirectPC(IdRedirectPC),
    .IdBranchValid(IdBranchValid), .IdBranchPC(IdBranchPC), .IdBranchTaken(IdBranchTaken),
    .IfIdValid(IfIdValid), .IfIdInstr(IfIdInstr), .IfIdPC(IfIdPC),
    .IfIdPCPlus4(IfIdPCPlus4), .IfIdPredTaken(IfIdPredTaken)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural model: counters as small integers clamped to 0..3.
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4;
  logic        m_valid, m_pred;
  int          m_cnt [16];

  task automatic m_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_idpc = 32'h0; m_idpc4 = 32'h0;
    m_valid = 1'b0; m_pred = 1'b0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 1;
  endtask

  task automatic m_step();
    int          op, simm, bi, c;
    logic        br, pr;
    logic [31:0] tgt;
    if (Stall || ICacheStall) return;
    op   = int'(IcacheRdata[31:26]);
    br   = (op == 4) || (op == 5);
    pr   = br && (m_cnt[(m_pc / 4) % 16] >= 2);
    simm = int'($signed(IcacheRdata[15:0]));
    tgt  = m_pc + 32'd4 + 32'(simm * 4);
    m_idpc  = m_pc;
    m_idpc4 = m_pc + 32'd4;
    if (IdRedirect) begin
      m_valid = 1'b0; m_instr = 32'h0; m_pred = 1'b0;
    end else begin
      m_valid = 1'b1; m_instr = IcacheRdata; m_pred = pr;
    end
    if (IdBranchValid) begin
      bi = int'((IdBranchPC / 4) % 16);
      c  = m_cnt[bi] + (IdBranchTaken ? 1 : -1);
      m_cnt[bi] = (c > 3) ? 3 : (c < 0) ? 0 : c;
    end
    m_pc = IdRedirect ? IdRedirectPC : (pr ? tgt : m_pc + 32'd4);
  endtask

  task automatic chk_ifid(input string tag);
    chk({tag, "_vld"},  {31'h0, IfIdValid},     {31'h0, m_valid});
    chk({tag, "_ins"},  IfIdInstr,              m_instr);
    chk({tag, "_pc"},   IfIdPC,                 m_idpc);
    chk({tag, "_pc4"},  IfIdPCPlus4,            m_idpc4);
    chk({tag, "_pred"}, {31'h0, IfIdPredTaken}, {31'h0, m_pred});
  endtask

  // One clock: caller has set inputs at posedge+1.
  task automatic cyc();
    #1;
    chk("addr", IcacheAddr, m_pc);
    chk("read", {31'h0, IcacheRead}, 32'h1);
    m_step();
    @(posedge clk);
    #1;
    chk_ifid("ifid");
  endtask

  task automatic clr_in();
    Stall = 0; ICacheStall = 0; IdRedirect = 0; IdRedirectPC = 0;
    IdBranchValid = 0; IdBranchPC = 0; IdBranchTaken = 0; IcacheRdata = 32'h0;
  endtask

  task automatic upd(input logic [31:0] bpc, input logic taken, input int n);
    for (int i = 0; i < n; i++) begin
      clr_in(); IdBranchValid = 1; IdBranchPC = bpc; IdBranchTaken = taken;
      cyc();
    end
    clr_in();
  endtask

  task automatic goto_pc(input logic [31:0] tpc);
    clr_in(); IdRedirect = 1; IdRedirectPC = tpc;
    cyc();
    clr_in();
  endtask

  localparam logic [31:0] BEQ_P3 = 32'h1000_0003;
  localparam logic [31:0] BEQ_M1 = 32'h1000_FFFF;

  initial begin
    m_reset();
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", {31'h0, IcacheRead}, 32'h0);
    chk("rst_addr", IcacheAddr, 32'h0);
    chk_ifid("rst");
    rst = 0;

    // Nop stream after reset.
    chk("boot_addr0", IcacheAddr, 32'h0);
    cyc();
    chk("boot_addr1", IcacheAddr, 32'h4);
    chk("boot_idpc", IfIdPC, 32'h0);
    chk("boot_vld", {31'h0, IfIdValid}, 32'h1);
    cyc();
    chk("boot_addr2", IcacheAddr, 32'h8);
    cyc(); cyc();

    // beq at 0x10, fresh counter: not taken.
    IcacheRdata = BEQ_P3;
    cyc();
    chk("beq_nt_addr", IcacheAddr, 32'h14);
    chk("beq_nt_pred", {31'h0, IfIdPredTaken}, 32'h0);
    upd(32'h10, 1'b1, 1);
    IdBranchValid = 1; IdBranchPC = 32'h10; IdBranchTaken = 1;
    IdRedirect = 1; IdRedirectPC = 32'h10;
    cyc();
    clr_in(); IcacheRdata = BEQ_P3;
    cyc();
    chk("beq_t_addr", IcacheAddr, 32'h20);
    chk("beq_t_pred", {31'h0, IfIdPredTaken}, 32'h1);

    // Saturation on entry 4.
    upd(32'h10, 1'b1, 5);
    upd(32'h10, 1'b0, 1);
    goto_pc(32'h10);
    IcacheRdata = BEQ_M1;
    cyc();
    chk("sat10_addr", IcacheAddr, 32'h10);
    chk("sat10_pred", {31'h0, IfIdPredTaken}, 32'h1);
    upd(32'h10, 1'b0, 2);
    goto_pc(32'h10);
    IcacheRdata = BEQ_M1;
    cyc();
    chk("sat00_addr", IcacheAddr, 32'h14);
    chk("sat00_pred", {31'h0, IfIdPredTaken}, 32'h0);

    // Hold via Stall, then via ICacheStall: redirect and updates ignored.
    for (int k = 0; k < 2; k++) begin
      clr_in();
      if (k == 0) Stall = 1; else ICacheStall = 1;
      IdRedirect = 1; IdRedirectPC = 32'h40;
      IdBranchValid = 1; IdBranchPC = 32'h10; IdBranchTaken = 1;
      IcacheRdata = BEQ_P3;
      repeat (3) cyc();
      chk("hold_addr", IcacheAddr, 32'h14);
      goto_pc(32'h10);
      IcacheRdata = BEQ_P3;
      cyc();
      chk("hold_cnt_addr", IcacheAddr, 32'h14);
    end

    // Redirect beats a predicted-taken branch.
    upd(32'h10, 1'b1, 2);
    goto_pc(32'h10);
    IcacheRdata = BEQ_M1; IdRedirect = 1; IdRedirectPC = 32'h40;
    cyc();
    chk("redir_addr", IcacheAddr, 32'h40);
    chk("redir_vld", {31'h0, IfIdValid}, 32'h0);
    chk("redir_ins", IfIdInstr, 32'h0);
    clr_in();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      clr_in();
      Stall       = ($urandom_range(0, 99) < 12);
      ICacheStall = ($urandom_range(0, 99) < 8);
      IdRedirect  = ($urandom_range(0, 99) < 10);
      IdRedirectPC = $urandom & 32'h0000_00FC;
      IdBranchValid = ($urandom_range(0, 99) < 35);
      IdBranchPC    = $urandom & 32'h0000_003C;
      IdBranchTaken = $urandom_range(0, 1);
      if ($urandom_range(0, 99) < 40)
        IcacheRdata = {($urandom_range(0, 1) ? 6'h04 : 6'h05), 10'($urandom),
                       16'(int'($urandom_range(0, 16)) - 8)};
      else
        IcacheRdata = {6'h23, 26'($urandom)};
      cyc();
    end

    // Asynchronous reset while the I-cache stalls.
    upd(32'h0, 1'b1, 2);
    ICacheStall = 1;
    #2 rst = 1;
    #1;
    m_reset();
    chk("arst_read", {31'h0, IcacheRead}, 32'h0);
    chk("arst_addr", IcacheAddr, 32'h0);
    chk_ifid("arst");
    @(posedge clk);
    #1 rst = 0;
    clr_in();
    chk("post_rst_addr", IcacheAddr, 32'h0);
    IcacheRdata = BEQ_P3;
    cyc();
    chk("post_rst_cnt_addr", IcacheAddr, 32'h4);
    chk("post_rst_cnt_pred", {31'h0, IfIdPredTaken}, 32'h0);
    clr_in();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
